// File: rtl/quantile_vpu_pkg.sv
// Shared opcodes, instruction field positions and FSM state type for quantile_vpu.
package quantile_pkg;

  localparam logic [3:0] OP_VADD    = 4'h0;
  localparam logic [3:0] OP_VSUB    = 4'h1;
  localparam logic [3:0] OP_VSMUL   = 4'h2;
  localparam logic [3:0] OP_VMAX    = 4'h3;
  localparam logic [3:0] OP_VMIN    = 4'h4;
  localparam logic [3:0] OP_VREDSUM = 4'h5;
  localparam logic [3:0] OP_STORE   = 4'h8;
  localparam logic [3:0] OP_LOAD    = 4'h9;

  localparam int OPC_LSB = 28;
  localparam int RS2_LSB = 23;
  localparam int RS1_LSB = 18;
  localparam int RD_LSB  = 13;
  localparam int IDX_LSB = 8;

  typedef enum logic {S_IDLE = 1'b0, S_EXEC = 1'b1} state_t;

  // Elementwise ops that run through the lane ALUs and write rd.
  function automatic logic is_lane_op(logic [3:0] op);
    return (op == OP_VADD) || (op == OP_VSUB) || (op == OP_VSMUL) ||
           (op == OP_VMAX) || (op == OP_VMIN);
  endfunction

endpackage

// File: rtl/quantile_vpu_if.sv
// Host-side instruction/data bundle for quantile_vpu; master = host, slave = VPU.
interface quantile_vpu_if #(parameter int DW = 32);
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instruction;
  logic [DW-1:0] input_data;
  logic          out_valid;
  logic [DW-1:0] output_data;
  logic          busy;

  modport master (
    output instr_valid, instruction, input_data,
    input  instr_ready, out_valid, output_data, busy
  );

  modport slave (
    input  instr_valid, instruction, input_data,
    output instr_ready, out_valid, output_data, busy
  );
endinterface

// File: rtl/quantile_lane.sv
// Combinational single-element ALU: add, sub, scalar multiply, signed max/min.
module quantile_lane
  import quantile_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [3:0]           op_i,
  input  logic signed [DW-1:0] a_i,
  input  logic signed [DW-1:0] b_i,
  input  logic signed [DW-1:0] s_i,
  output logic signed [DW-1:0] y_o
);

  always_comb begin
    y_o = a_i;
    case (op_i)
      OP_VADD:  y_o = a_i + b_i;
      OP_VSUB:  y_o = a_i - b_i;
      OP_VSMUL: y_o = a_i * s_i;
      OP_VMAX:  y_o = (a_i > b_i) ? a_i : b_i;
      OP_VMIN:  y_o = (a_i < b_i) ? a_i : b_i;
      default:  y_o = a_i;
    endcase
  end

endmodule

// File: rtl/quantile_vpu.sv
// Multi-cycle vector unit: regfile, IDLE/EXEC FSM, LANES-wide beats.
// Optional VREDSUM reduction compiled in with QUANTILE_VPU_REDUCE_EN.
module quantile_vpu
  import quantile_pkg::*;
#(
  parameter int LANES = 4,
  parameter int VLEN  = 8,
  parameter int NREGS = 32,
  parameter int DW    = 32
) (
  input  logic            clk,
  input  logic            rst,
  quantile_vpu_if.slave   bus
);

  localparam int BEATS  = VLEN / LANES;
  localparam int IDX_W  = (VLEN > 1) ? $clog2(VLEN) : 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_t               state_q;
  logic [BEAT_W-1:0]    beat_q;
  logic [3:0]           op_q;
  logic [4:0]           rs1_q, rs2_q, rd_q;
  logic signed [DW-1:0] scal_q;
  logic                 out_valid_q;
  logic [DW-1:0]        out_data_q;
  logic [DW-1:0]        rf_q [NREGS][VLEN];

  logic [3:0]       opc_w;
  logic [4:0]       rs1_w, rs2_w, rd_w;
  logic [IDX_W-1:0] idx_w;
  logic             fire_w, start_w, last_w;
  logic             unused_instr_bits;

  assign opc_w  = bus.instruction[OPC_LSB +: 4];
  assign rs2_w  = bus.instruction[RS2_LSB +: 5];
  assign rs1_w  = bus.instruction[RS1_LSB +: 5];
  assign rd_w   = bus.instruction[RD_LSB +: 5];
  assign idx_w  = bus.instruction[IDX_LSB +: IDX_W];
  assign unused_instr_bits = ^{bus.instruction[IDX_LSB-1:0], bus.instruction[12:IDX_LSB+IDX_W]};
  assign fire_w = bus.instr_valid && (state_q == S_IDLE);
  assign last_w = (beat_q == BEAT_W'(BEATS - 1));

`ifdef QUANTILE_VPU_REDUCE_EN
  assign start_w = is_lane_op(opc_w) || (opc_w == OP_VREDSUM);
`else
  assign start_w = is_lane_op(opc_w);
`endif

  function automatic logic in_range(logic [4:0] r);
    return {1'b0, r} < 6'(NREGS);
  endfunction

  // Out-of-range register addresses read as zero.
  function automatic logic [DW-1:0] rd_elem(logic [4:0] r, logic [IDX_W-1:0] e);
    return in_range(r) ? rf_q[r][e] : '0;
  endfunction

  logic [IDX_W-1:0]     eidx_w [LANES];
  logic signed [DW-1:0] a_w    [LANES];
  logic signed [DW-1:0] b_w    [LANES];
  logic signed [DW-1:0] y_w    [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign eidx_w[l] = IDX_W'(int'(beat_q) * LANES + l);
    assign a_w[l]    = rd_elem(rs1_q, eidx_w[l]);
    assign b_w[l]    = rd_elem(rs2_q, eidx_w[l]);
    quantile_lane #(.DW(DW)) u_lane (
      .op_i (op_q),
      .a_i  (a_w[l]),
      .b_i  (b_w[l]),
      .s_i  (scal_q),
      .y_o  (y_w[l])
    );
  end

`ifdef QUANTILE_VPU_REDUCE_EN
  logic [DW-1:0] acc_q;
  logic [DW-1:0] lane_sum_w;
  always_comb begin
    lane_sum_w = '0;
    for (int l = 0; l < LANES; l++) lane_sum_w = lane_sum_w + a_w[l];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      op_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      scal_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef QUANTILE_VPU_REDUCE_EN
      acc_q       <= '0;
`endif
      for (int r = 0; r < NREGS; r++)
        for (int e = 0; e < VLEN; e++) rf_q[r][e] <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (fire_w) begin
            if (start_w) begin
              state_q <= S_EXEC;
              beat_q  <= '0;
              op_q    <= opc_w;
              rs1_q   <= rs1_w;
              rs2_q   <= rs2_w;
              rd_q    <= rd_w;
              scal_q  <= rd_elem(rs2_w, idx_w);
`ifdef QUANTILE_VPU_REDUCE_EN
              acc_q   <= '0;
`endif
            end else if (opc_w == OP_STORE) begin
              if (in_range(rd_w)) rf_q[rd_w][idx_w] <= bus.input_data;
            end else if (opc_w == OP_LOAD) begin
              out_valid_q <= 1'b1;
              out_data_q  <= rd_elem(rs1_w, idx_w);
            end
          end
        end
        S_EXEC: begin
          // Each beat reads and rewrites only its own LANES elements, so rd may alias a source.
          if (is_lane_op(op_q) && in_range(rd_q))
            for (int l = 0; l < LANES; l++) rf_q[rd_q][eidx_w[l]] <= y_w[l];
`ifdef QUANTILE_VPU_REDUCE_EN
          acc_q <= acc_q + lane_sum_w;
`endif
          if (last_w) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
`ifdef QUANTILE_VPU_REDUCE_EN
            if (op_q == OP_VREDSUM) begin
              out_valid_q <= 1'b1;
              out_data_q  <= acc_q + lane_sum_w;
            end
`endif
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.instr_ready = (state_q == S_IDLE);
  assign bus.busy        = (state_q == S_EXEC);
  assign bus.out_valid   = out_valid_q;
  assign bus.output_data = out_data_q;

endmodule

// File: tb/tb_quantile_vpu.sv
// Self-checking bench for quantile_vpu: directed vector table, multi-cycle corner sequences,
// then random instructions against a plain-array reference model.
module tb_quantile_vpu;
  import quantile_pkg::*;

  localparam int LANES = 4;
  localparam int VLEN  = 8;
  localparam int NREGS = 32;
  localparam int DW    = 32;
  localparam int BEATS = VLEN / LANES;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  quantile_vpu_if #(.DW(DW)) bus ();

  quantile_vpu #(.LANES(LANES), .VLEN(VLEN), .NREGS(NREGS), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(logic [3:0] op, int rs1, int rs2, int rd, int idx);
    logic [31:0] w;
    w = '0;
    w[31:28] = op;
    w[27:23] = 5'(rs2);
    w[22:18] = 5'(rs1);
    w[17:13] = 5'(rd);
    w[12:8]  = 5'(idx);
    return w;
  endfunction

  // Issue one instruction from a negedge and follow it until the unit is ready again.
  task automatic run_instr(input logic [31:0] ins, input logic [31:0] data,
                           output logic pulse, output logic [31:0] val,
                           output int busy_n, output int pulse_k);
    int k;
    pulse = 1'b0; val = '0; busy_n = 0; pulse_k = -1;
    k = 0;
    while (!bus.instr_ready && k < 50) begin @(negedge clk); k++; end
    if (!bus.instr_ready) begin
      check("ready_timeout", 32'(bus.instr_ready), 32'd1);
      return;
    end
    bus.instruction = ins;
    bus.input_data  = data;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    for (k = 1; k < 50; k++) begin
      if (bus.out_valid) begin pulse = 1'b1; val = bus.output_data; pulse_k = k; end
      if (bus.busy) busy_n++;
      if (bus.instr_ready) break;
      @(negedge clk);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic [31:0] data;
    logic        exp_pulse;
    logic [31:0] exp_val;
    int          exp_busy;
    int          exp_lat;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(string n, logic [31:0] ins, logic [31:0] d, logic p,
                              logic [31:0] v, int b, int lat);
    vec_t t;
    t.name = n; t.ins = ins; t.data = d; t.exp_pulse = p;
    t.exp_val = v; t.exp_busy = b; t.exp_lat = lat;
    tbl.push_back(t);
  endfunction

  int m [NREGS][VLEN];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        pulse, saw;
    logic [31:0] val;
    int          busy_n, pulse_k, k;
    logic [3:0]  ops [13];

    rst = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instruction = '0;
    bus.input_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", 32'(bus.instr_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_output_data", bus.output_data, 32'd0);

    add("ld_r0_3", mk(OP_LOAD, 0, 0, 0, 3), 0, 1, 0, 0, 1);
    for (int i = 0; i < VLEN; i++) add("st_r1", mk(OP_STORE, 0, 0, 1, i), 32'd5, 0, 0, 0, -1);
    for (int i = 0; i < VLEN; i++) add("st_r2", mk(OP_STORE, 0, 0, 2, i), 32'hFFFF_FFFD, 0, 0, 0, -1);
    add("vadd_r3", mk(OP_VADD, 1, 2, 3, 0), 0, 0, 0, BEATS, -1);
    add("ld_r3_7", mk(OP_LOAD, 3, 0, 0, 7), 0, 1, 32'd2, 0, 1);
    add("ld_r3_idx_hi", mk(OP_LOAD, 3, 0, 0, 15), 0, 1, 32'd2, 0, 1);
    add("vsmul_r4", mk(OP_VSMUL, 1, 2, 4, 2), 0, 0, 0, BEATS, -1);
    add("ld_r4_0", mk(OP_LOAD, 4, 0, 0, 0), 0, 1, 32'hFFFF_FFF1, 0, 1);
    add("ld_r4_5", mk(OP_LOAD, 4, 0, 0, 5), 0, 1, 32'hFFFF_FFF1, 0, 1);
    add("vmax_r5", mk(OP_VMAX, 1, 2, 5, 0), 0, 0, 0, BEATS, -1);
    add("ld_r5_6", mk(OP_LOAD, 5, 0, 0, 6), 0, 1, 32'd5, 0, 1);
    add("vmin_r6", mk(OP_VMIN, 1, 2, 6, 0), 0, 0, 0, BEATS, -1);
    add("ld_r6_1", mk(OP_LOAD, 6, 0, 0, 1), 0, 1, 32'hFFFF_FFFD, 0, 1);
    add("nop_a", mk(4'hA, 1, 2, 3, 0), 0, 0, 0, 0, -1);
    add("ld_r3_0_after_nop", mk(OP_LOAD, 3, 0, 0, 0), 0, 1, 32'd2, 0, 1);
    for (int i = 0; i < VLEN; i++) add("st_r7", mk(OP_STORE, 0, 0, 7, i), 32'h7FFF_FFFF, 0, 0, 0, -1);
`ifdef QUANTILE_VPU_REDUCE_EN
    add("vredsum_r7", mk(OP_VREDSUM, 7, 0, 0, 0), 0, 1, 32'hFFFF_FFF8, BEATS, BEATS + 1);
`else
    add("vredsum_nop", mk(OP_VREDSUM, 7, 0, 0, 0), 0, 0, 0, 0, -1);
`endif
    add("ld_r20_0", mk(OP_LOAD, 20, 0, 0, 0), 0, 1, 32'd0, 0, 1);

    foreach (tbl[i]) begin
      run_instr(tbl[i].ins, tbl[i].data, pulse, val, busy_n, pulse_k);
      check({tbl[i].name, "_pulse"}, 32'(pulse), 32'(tbl[i].exp_pulse));
      check({tbl[i].name, "_busy"}, 32'(busy_n), 32'(tbl[i].exp_busy));
      if (tbl[i].exp_pulse) begin
        check({tbl[i].name, "_data"}, val, tbl[i].exp_val);
        check({tbl[i].name, "_lat"}, 32'(pulse_k), 32'(tbl[i].exp_lat));
      end
    end

    // In-place VSUB with the following LOAD held on the bus throughout EXEC.
    bus.instruction = mk(OP_VSUB, 1, 1, 1, 0);
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instruction = mk(OP_LOAD, 1, 0, 0, 4);
    saw = 1'b0;
    for (k = 1; k < 20; k++) begin
      if (bus.instr_ready) break;
      if (bus.out_valid) saw = 1'b1;
      @(negedge clk);
    end
    check("vsub_accept_cycle", 32'(k), 32'(BEATS + 1));
    check("vsub_no_early_pulse", 32'(saw), 32'd0);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    check("vsub_held_load_pulse", 32'(bus.out_valid), 32'd1);
    check("vsub_held_load_data", bus.output_data, 32'd0);
    run_instr(mk(OP_LOAD, 1, 0, 0, 0), 0, pulse, val, busy_n, pulse_k);
    check("vsub_r1_0", val, 32'd0);

    // Reset during the first EXEC beat abandons the operation and clears the regfile.
`ifdef QUANTILE_VPU_REDUCE_EN
    bus.instruction = mk(OP_VREDSUM, 7, 0, 0, 0);
`else
    bus.instruction = mk(OP_VADD, 3, 3, 8, 0);
`endif
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    check("rst_exec_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.out_valid) saw = 1'b1;
      @(negedge clk);
    end
    check("rst_exec_no_pulse", 32'(saw), 32'd0);
    check("rst_exec_ready", 32'(bus.instr_ready), 32'd1);
    run_instr(mk(OP_LOAD, 3, 0, 0, 7), 0, pulse, val, busy_n, pulse_k);
    check("rst_exec_r3_7", val, 32'd0);
    run_instr(mk(OP_LOAD, 7, 0, 0, 0), 0, pulse, val, busy_n, pulse_k);
    check("rst_exec_r7_0", val, 32'd0);

    // Random instructions against the reference model (regfile is all zero here).
    for (int r = 0; r < NREGS; r++) for (int e = 0; e < VLEN; e++) m[r][e] = 0;
    ops = '{OP_VADD, OP_VSUB, OP_VSMUL, OP_VMAX, OP_VMIN, OP_VREDSUM,
            OP_STORE, OP_STORE, OP_STORE, OP_LOAD, OP_LOAD, 4'hB, 4'h6};
    for (int n = 0; n < 300; n++) begin
      logic [3:0]  op;
      int          rs1, rs2, rd, idx, e_idx, s, sum, ebusy;
      logic        ep;
      logic [31:0] ev, data;
      int          res [VLEN];
      op   = ops[$urandom_range(12, 0)];
      rs1  = $urandom_range(5, 0);
      rs2  = $urandom_range(5, 0);
      rd   = $urandom_range(5, 0);
      idx  = $urandom_range(31, 0);
      data = $urandom;
      if ($urandom_range(3, 0) == 0) data = {1'b0, {31{1'b1}}} + 32'($urandom_range(2, 0));
      e_idx = idx % VLEN;
      ep = 1'b0; ev = '0; ebusy = 0;
      case (op)
        OP_VADD, OP_VSUB, OP_VSMUL, OP_VMAX, OP_VMIN: begin
          s = m[rs2][e_idx];
          for (int e = 0; e < VLEN; e++) begin
            case (op)
              OP_VADD: res[e] = m[rs1][e] + m[rs2][e];
              OP_VSUB: res[e] = m[rs1][e] - m[rs2][e];
              OP_VSMUL: res[e] = m[rs1][e] * s;
              OP_VMAX: res[e] = (m[rs1][e] > m[rs2][e]) ? m[rs1][e] : m[rs2][e];
              default: res[e] = (m[rs1][e] < m[rs2][e]) ? m[rs1][e] : m[rs2][e];
            endcase
          end
          for (int e = 0; e < VLEN; e++) m[rd][e] = res[e];
          ebusy = BEATS;
        end
        OP_VREDSUM: begin
`ifdef QUANTILE_VPU_REDUCE_EN
          sum = 0;
          for (int e = 0; e < VLEN; e++) sum = sum + m[rs1][e];
          ep = 1'b1; ev = sum; ebusy = BEATS;
`endif
        end
        OP_STORE: m[rd][e_idx] = data;
        OP_LOAD: begin ep = 1'b1; ev = m[rs1][e_idx]; end
        default: ;
      endcase
      run_instr(mk(op, rs1, rs2, rd, idx), data, pulse, val, busy_n, pulse_k);
      check($sformatf("rnd%0d_op%0h_pulse", n, op), 32'(pulse), 32'(ep));
      check($sformatf("rnd%0d_op%0h_busy", n, op), 32'(busy_n), 32'(ebusy));
      if (ep) check($sformatf("rnd%0d_op%0h_data", n, op), val, ev);
    end

    // Final sweep of the registers touched by the random phase.
    for (int r = 0; r < 6; r++) begin
      for (int e = 0; e < VLEN; e++) begin
        run_instr(mk(OP_LOAD, r, 0, 0, e), 0, pulse, val, busy_n, pulse_k);
        check($sformatf("sweep_r%0d_%0d", r, e), val, 32'(m[r][e]));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/quantile_vpu.md
# quantile_vpu

Parametrised, multi-cycle successor to the single-cycle quantile vector datapath: decodes the same 32-bit instruction format, holds a NREGS x VLEN x DW vector register file, and executes vector ops LANES elements per cycle behind a valid/ready instruction handshake. Adds a signed-sum reduction to scalar, compiled in or out. Sits between the host instruction/data interface and the quantile-regression loss/update logic.

## Interface
- LANES, 4, elements processed per beat; VLEN % LANES == 0
- VLEN, 8, elements per vector register
- NREGS, 32, vector registers; at most 32 (5-bit address)
- DW, 32, element width in bits
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction present
- instr_ready  out  1  block can accept an instruction
- instruction  in  32  [31:28] opcode, [27:23] rs2, [22:18] rs1, [17:13] rd, [12:8] index
- input_data  in  DW  scalar for STORE
- out_valid  out  1  one-cycle pulse, output_data valid
- output_data  out  DW  LOAD/REDSUM result, held until next pulse
- busy  out  1  high while in EXEC

## Operation
- Accept = instr_valid && instr_ready; fields latched on accept.
- States: IDLE (instr_ready=1), EXEC (instr_ready=0). BEATS = VLEN/LANES.
- Opcodes (two's-complement, results truncated to DW, no saturation):
  - 0000 VADD rd = rs1 + rs2; 0001 VSUB rd = rs1 - rs2
  - 0010 VSMUL rd = rs1 * S, low DW bits, S = rs2[index] latched at accept
  - 0011 VMAX, 0100 VMIN, signed, elementwise
  - 0101 VREDSUM: output_data = sum of rs1 elements mod 2^DW, no write
  - 1000 STORE: rd[index] = input_data; 1001 LOAD: output_data = rs1[index]
  - all other opcodes: NOP, no write, no pulse
- index uses low clog2(VLEN) bits; upper bits ignored. Register addresses >= NREGS: write dropped, reads return 0.
- Vector ops and VREDSUM: IDLE -> EXEC; beat counter 0..BEATS-1 processes elements [beat*LANES +: LANES]; writes per beat; last beat -> IDLE.
- rd == rs1 or rs2 is legal: each beat reads elements it has not yet overwritten.
- STORE, LOAD, NOP: complete in IDLE, no EXEC entry.

## Timing
- Reset: regfile all 0, state IDLE, beat 0, instr_ready=1, out_valid=0, output_data=0, busy=0.
- Vector op accepted in cycle t: beats in t+1..t+BEATS; instr_ready=0 in those cycles; result readable and instr_ready=1 in t+BEATS+1.
- VREDSUM accepted in t: out_valid=1 in t+BEATS+1 with sum.
- LOAD accepted in t: out_valid=1 in t+1; instr_ready stays 1 (back-to-back LOADs give one pulse per cycle).
- STORE accepted in t: written at end of t, visible to an instruction accepted in t+1.
- instr_valid while instr_ready=0: ignored, must be held by sender.
- rst during EXEC: operation abandoned, no out_valid, regfile cleared, IDLE next cycle.

## Configuration
- QUANTILE_VPU_REDUCE_EN defined: VREDSUM implemented as above (accumulator + adder tree over LANES).
- Undefined: opcode 0101 decodes as NOP, no accumulator hardware, no out_valid from it.

## Structure
- Shared package quantile_pkg: opcode localparams, FSM state typedef, instruction field bit positions.
- One sub-module quantile_lane: combinational single-element ALU (add/sub/smul/max/min), instantiated LANES times.
- Top holds FSM, beat counter, regfile, accumulator, output register.

## Test plan
- Reset, then LOAD r0[3] -> out_valid at t+1, output_data=0; instr_ready=1 throughout.
- STORE 5 into r1[0..7], STORE -3 into r2[0..7], VADD r3=r1+r2 (LANES=4) -> busy 2 cycles, then LOAD r3[7] = 2.
- VSMUL r4=r1*r2[2] -> every r4 element = -15; VMAX r5=r1,r2 -> 5; VMIN -> -3.
- r1 = 0x7FFFFFFF all elements, VREDSUM r1 (REDUCE_EN) -> output_data = 0xFFFFFFF8 at t+BEATS+1; without macro -> no pulse.
- In-place VSUB r1=r1-r1 with instr_valid held high during EXEC -> r1 all 0, second instruction accepted only at t+BEATS+1.
- Assert rst on the first EXEC beat -> no out_valid, LOAD of any element returns 0.
